// File: rtl/wiener_output_writer_if.sv
// rtl/wiener_output_writer_if.sv - pixel stream and burst write-control bundle
// master = the output writer, slave = the pixel source plus AXI burst master.
interface wiener_output_writer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    pixel_valid;
  logic [DATA_WIDTH-1:0]   pixel_data;
  logic                    pixel_ready;
  logic                    start_write;
  logic [ADDR_WIDTH-1:0]   write_addr;
  logic [31:0]             write_len;
  logic [2:0]              write_size;
  logic [1:0]              write_burst;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH/8-1:0] write_strb;
  logic                    write_beat_ack;
  logic                    write_done;

  modport master (
    input  pixel_valid, pixel_data, write_beat_ack, write_done,
    output pixel_ready, start_write, write_addr, write_len, write_size,
           write_burst, write_data, write_strb
  );

  modport slave (
    output pixel_valid, pixel_data, write_beat_ack, write_done,
    input  pixel_ready, start_write, write_addr, write_len, write_size,
           write_burst, write_data, write_strb
  );
endinterface

// File: rtl/wiener_output_writer.sv
// rtl/wiener_output_writer.sv - buffers filtered block rows and bursts each one
// to its raster position in the output frame buffer.
module wiener_output_writer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           frame_height,
  input  logic [15:0]           frame_width,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic                  start_of_frame,
  output logic                  frame_done,
  output logic                  busy,
  wiener_output_writer_if.master bus
);
  localparam int LOG_BS = $clog2(BLOCK_SIZE);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_ISSUE, S_DATA, S_RESP, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [LOG_BS-1:0]     r_q, r_d, beat_q, beat_d;
  logic [15:0]           bx_q, bx_d, by_q, by_d;
  logic [15:0]           fw_q, fw_d, fh_q, fh_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
  logic                  const_en_q;

  logic        ready, push, pop, start_write_c, frame_done_c, last_row;
  logic [15:0] bw_last, bh_last;
  logic [31:0] row_off, row_addr_32;

  assign ready = (state_q != S_IDLE) && (count_q != CNT_W'(FIFO_DEPTH));
  assign push  = bus.pixel_valid && ready;

  assign bw_last  = (fw_q >> LOG_BS) - 16'd1;
  assign bh_last  = (fh_q >> LOG_BS) - 16'd1;
  assign last_row = (r_q == LOG_BS'(BLOCK_SIZE - 1)) && (bx_q == bw_last) && (by_q == bh_last);

  // Byte offset of the current block row inside the frame, 32-bit unsigned.
  assign row_off = ((32'(by_q) * 32'(BLOCK_SIZE) + 32'(r_q)) * 32'(fw_q)
                    + 32'(bx_q) * 32'(BLOCK_SIZE)) << 2;
  assign row_addr_32 = 32'(base_q) + row_off;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      r_q        <= '0;
      beat_q     <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      fw_q       <= '0;
      fh_q       <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      const_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      beat_q     <= beat_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      fw_q       <= fw_d;
      fh_q       <= fh_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      const_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    r_d           = r_q;
    beat_d        = beat_q;
    bx_d          = bx_q;
    by_d          = by_q;
    fw_d          = fw_q;
    fh_d          = fh_q;
    base_d        = base_q;
    addr_d        = addr_q;
    pop           = 1'b0;
    start_write_c = 1'b0;
    frame_done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_of_frame) begin
          fw_d    = frame_width;
          fh_d    = frame_height;
          base_d  = base_addr_in;
          r_d     = '0;
          bx_d    = '0;
          by_d    = '0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (count_q >= CNT_W'(BLOCK_SIZE)) begin
          addr_d  = ADDR_WIDTH'(row_addr_32);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        start_write_c = 1'b1;
        beat_d        = '0;
        state_d       = S_DATA;
      end
      S_DATA: begin
        if (bus.write_beat_ack) begin
          pop    = 1'b1;
          beat_d = beat_q + LOG_BS'(1);
          if (beat_q == LOG_BS'(BLOCK_SIZE - 1)) state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.write_done) begin
          // Row inside the block first, then block column, then block row.
          if (r_q == LOG_BS'(BLOCK_SIZE - 1)) begin
            r_d = '0;
            if (bx_q == bw_last) begin
              bx_d = '0;
              by_d = (by_q == bh_last) ? 16'd0 : by_q + 16'd1;
            end else begin
              bx_d = bx_q + 16'd1;
            end
          end else begin
            r_d = r_q + LOG_BS'(1);
          end
          state_d = last_row ? S_DONE : S_COLLECT;
        end
      end
      S_DONE: begin
        frame_done_c = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.pixel_data;
  end

  // Constant burst attributes read as zero until the first cycle out of reset.
  assign bus.pixel_ready = ready;
  assign bus.start_write = start_write_c;
  assign bus.write_addr  = addr_q;
  assign bus.write_len   = const_en_q ? 32'(BLOCK_SIZE - 1) : 32'd0;
  assign bus.write_size  = const_en_q ? 3'b010 : 3'b000;
  assign bus.write_burst = const_en_q ? 2'b01 : 2'b00;
  assign bus.write_strb  = const_en_q ? '1 : '0;
  assign bus.write_data  = (state_q == S_DATA) ? mem_q[rd_ptr_q] : '0;
  assign frame_done      = frame_done_c;
  assign busy            = (state_q != S_IDLE);
endmodule

// File: tb/tb_wiener_output_writer.sv
// tb/tb_wiener_output_writer.sv - directed frames checked against a burst-level
// model of where each block row of the frame must land.
module tb_wiener_output_writer;
  localparam int BS    = 8;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] frame_height = '0;
  logic [15:0] frame_width  = '0;
  logic [31:0] base_addr_in = '0;
  logic        start_of_frame = 1'b0;
  logic        frame_done, busy;

  wiener_output_writer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bif ();

  wiener_output_writer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_SIZE(BS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .frame_height(frame_height), .frame_width(frame_width),
    .base_addr_in(base_addr_in), .start_of_frame(start_of_frame),
    .frame_done(frame_done), .busy(busy), .bus(bif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit ack_en = 1'b0;
  bit stray_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  bit          m_active = 1'b0;
  int          m_fw = 0, m_fh = 0, total = 0;
  logic [31:0] m_base = '0;
  logic [31:0] pq[$];
  int          nb = 0, nresp = 0, beats = 0, push_n = 0;
  bit          in_burst = 1'b0, wait_resp = 1'b0, exp_done = 1'b0;
  logic [31:0] cur_addr = '0;
  logic [31:0] got_addr [0:63];
  int          t8 = 0, sw0_cyc = 0, done_cnt = 0, last_wd_cyc = 0, done_cyc = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  // Burst k covers block k/BS (raster order), row k%BS inside it.
  function automatic logic [31:0] model_addr(input int k);
    int bw, b, r, bx, by;
    bw = m_fw / BS;
    b  = k / BS;
    r  = k % BS;
    bx = b % bw;
    by = b / bw;
    return m_base + 32'(((by * BS + r) * m_fw + bx * BS) * 4);
  endfunction

  always @(negedge clk) begin
    logic [31:0] head;
    if (mon_en) begin
      chk("pixel_ready", bif.pixel_ready, m_active && (pq.size() < DEPTH));
      chk("busy", busy, m_active);
      chk("frame_done", frame_done, exp_done);
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      exp_done = 1'b0;
      if (wait_resp && bif.write_done) begin
        wait_resp = 1'b0;
        nresp++;
        last_wd_cyc = cyc;
        if (nresp == total) exp_done = 1'b1;
      end
      if (bif.start_write) begin
        chk("start_write_allowed", m_active && !in_burst && !wait_resp && (nb < total), 1);
        cur_addr = model_addr(nb);
        chk("write_addr", bif.write_addr, cur_addr);
        chk("write_len", bif.write_len, 7);
        chk("write_size", bif.write_size, 2);
        chk("write_burst", bif.write_burst, 1);
        chk("write_strb", bif.write_strb, 4'hF);
        if (nb < 64) got_addr[nb] = bif.write_addr;
        if (nb == 0) sw0_cyc = cyc;
        nb++;
        in_burst = 1'b1;
        beats = 0;
      end else if (in_burst) begin
        chk("addr_stable", bif.write_addr, cur_addr);
        if (bif.write_beat_ack) begin
          head = 'x;
          if (pq.size() > 0) head = pq.pop_front();
          chk("write_data", bif.write_data, head);
          beats++;
          if (beats == BS) begin
            in_burst = 1'b0;
            wait_resp = 1'b1;
          end
        end
      end else if (wait_resp) begin
        chk("addr_stable_resp", bif.write_addr, cur_addr);
      end
      if (bif.pixel_valid && bif.pixel_ready) begin
        pq.push_back(bif.pixel_data);
        if (push_n == BS - 1) t8 = cyc;
        push_n++;
      end
      if (start_of_frame && !m_active) begin
        m_active = 1'b1;
        m_fw = int'(frame_width);
        m_fh = int'(frame_height);
        m_base = base_addr_in;
        total = (m_fw / BS) * (m_fh / BS) * BS;
        nb = 0;
        nresp = 0;
        push_n = 0;
      end
      if (frame_done) m_active = 1'b0;
    end
    if (rst) begin
      m_active = 1'b0;
      pq.delete();
      in_burst = 1'b0;
      wait_resp = 1'b0;
      exp_done = 1'b0;
    end
  end

  // Burst slave: acks per ack_en, response two cycles after the last beat.
  initial begin
    int rsp_beats;
    bit rsp_on;
    int done_at;
    rsp_beats = 0;
    rsp_on = 1'b0;
    done_at = -10;
    bif.write_beat_ack = 1'b0;
    bif.write_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bif.write_beat_ack = ack_en;
      bif.write_done = (cyc == done_at) || stray_done;
      @(negedge clk);
      if (rst) begin
        rsp_on = 1'b0;
        rsp_beats = 0;
        done_at = -10;
      end else if (bif.start_write) begin
        rsp_on = 1'b1;
        rsp_beats = 0;
      end else if (rsp_on && bif.write_beat_ack) begin
        rsp_beats++;
        if (rsp_beats == BS) begin
          rsp_on = 1'b0;
          done_at = cyc + 2;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof(input int w, input int h, input logic [31:0] b);
    frame_width = 16'(w);
    frame_height = 16'(h);
    base_addr_in = b;
    start_of_frame = 1'b1;
    tick();
    start_of_frame = 1'b0;
  endtask

  task automatic push(input int n, input int first);
    int i, guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 5000) begin
      bif.pixel_valid = 1'b1;
      bif.pixel_data = 32'(first + i);
      @(negedge clk);
      if (bif.pixel_ready) i++;
      tick();
      guard++;
    end
    bif.pixel_valid = 1'b0;
    chk("push_timeout", 32'(i), 32'(n));
  endtask

  task automatic wait_done(input int budget);
    int n, start;
    n = 0;
    start = done_cnt;
    while (done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    chk("frame_done_seen", 32'(done_cnt - start), 1);
    tick();
  endtask

  task automatic check_reset_outputs();
    chk("rst_pixel_ready", bif.pixel_ready, 0);
    chk("rst_start_write", bif.start_write, 0);
    chk("rst_write_addr", bif.write_addr, 0);
    chk("rst_write_len", bif.write_len, 0);
    chk("rst_write_size", bif.write_size, 0);
    chk("rst_write_burst", bif.write_burst, 0);
    chk("rst_write_data", bif.write_data, 0);
    chk("rst_write_strb", bif.write_strb, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    int d0, acc, n;
    logic last_ready;
    bif.pixel_valid = 1'b0;
    bif.pixel_data = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    tick();
    rst = 1'b0;
    mon_en = 1'b1;

    // Idle: pixels and stray responses must be ignored.
    bif.pixel_valid = 1'b1;
    bif.pixel_data = 32'hAA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_pixel_ready", bif.pixel_ready, 0);
      tick();
    end
    bif.pixel_valid = 1'b0;

    // Frame A: 16x16 at 0x100, ack always high, mid-frame start and stray done.
    ack_en = 1'b1;
    d0 = done_cnt;
    sof(16, 16, 32'h100);
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    push(100, 0);
    sof(32, 32, 32'h9000);
    push(156, 100);
    wait_done(3000);
    repeat (5) tick();
    chk("A_bursts", 32'(nb), 32);
    chk("A_addr0", got_addr[0], 32'h100);
    chk("A_addr1", got_addr[1], 32'h140);
    chk("A_addr8", got_addr[8], 32'h120);
    chk("A_addr16", got_addr[16], 32'h300);
    chk("A_addr31", got_addr[31], 32'h4E0);
    chk("A_latency", 32'(sw0_cyc - t8), 2);
    chk("A_done_after_resp", 32'(done_cyc - last_wd_cyc), 1);
    chk("A_done_once", 32'(done_cnt - d0), 1);

    // Frame B: 8x8 at 0x2000 with backpressure until the FIFO fills.
    ack_en = 1'b0;
    sof(8, 8, 32'h2000);
    acc = 0;
    last_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bif.pixel_valid = 1'b1;
      bif.pixel_data = 32'(acc);
      @(negedge clk);
      last_ready = bif.pixel_ready;
      if (bif.pixel_ready) acc++;
      tick();
    end
    bif.pixel_valid = 1'b0;
    chk("B_accepted", 32'(acc), 16);
    chk("B_ready_full", last_ready, 0);
    ack_en = 1'b1;
    push(48, 16);
    wait_done(3000);
    chk("B_bursts", 32'(nb), 8);
    chk("B_addr0", got_addr[0], 32'h2000);
    chk("B_addr1", got_addr[1], 32'h2020);
    chk("B_addr7", got_addr[7], 32'h20E0);

    // Frame C: reset after three beats of the first burst.
    ack_en = 1'b0;
    sof(16, 16, 32'h0);
    push(8, 500);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bif.start_write && n < 200);
    chk("C_start_seen", bif.start_write, 1);
    ack_en = 1'b1;
    repeat (4) @(posedge clk);
    ack_en = 1'b0;
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs();
    tick();
    rst = 1'b0;

    // Frame D: a fresh 8x8 frame must start again from burst 0.
    ack_en = 1'b1;
    sof(8, 8, 32'h4000);
    push(64, 1000);
    wait_done(3000);
    chk("D_bursts", 32'(nb), 8);
    chk("D_addr0", got_addr[0], 32'h4000);
    chk("D_addr3", got_addr[3], 32'h4060);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wiener_output_writer.md
Name: wiener_output_writer

Overview:
Downstream stage of wiener_3_channels. It accepts filtered pixels, which arrive block by block in raster block order and row by row inside each block. It buffers each block row in a small FIFO. It drives the write-control interface of an AXI_memory_master_burst instance so that each block row is written to its raster position in an output frame buffer. A one-cycle frame_done pulse marks the final write response of the frame.

Parameters:
ADDR_WIDTH, 32, address width of write_addr and base_addr_in
DATA_WIDTH, 32, pixel width ({8'h0,R,G,B})
BLOCK_SIZE, 8, block edge in pixels; power of 2, at least 2
FIFO_DEPTH, 16, pixel FIFO entries; power of 2, at least 2*BLOCK_SIZE

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
frame_height  in  16  frame rows; multiple of BLOCK_SIZE; sampled at start_of_frame
frame_width  in  16  frame columns; multiple of BLOCK_SIZE; sampled at start_of_frame
base_addr_in  in  ADDR_WIDTH  output frame byte base address; sampled at start_of_frame
start_of_frame  in  1  one-cycle pulse that arms the block for a new frame
pixel_valid  in  1  pixel_data valid
pixel_data  in  DATA_WIDTH  filtered pixel
pixel_ready  out  1  FIFO can accept a pixel
start_write  out  1  one-cycle burst request to the AXI master
write_addr  out  ADDR_WIDTH  burst byte address
write_len  out  32  AXI awlen encoding, i.e. beats minus 1
write_size  out  3  constant 3'b010 (4 bytes)
write_burst  out  2  constant 2'b01 (INCR)
write_data  out  DATA_WIDTH  current beat, taken from the FIFO head
write_strb  out  DATA_WIDTH/8  constant all ones
write_beat_ack  in  1  master consumed write_data this cycle
write_done  in  1  burst write response received (bvalid & bready)
frame_done  out  1  one-cycle pulse at the end of the frame
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0; FIFO empty; counters 0; state IDLE. Reset asserted mid-burst aborts the burst. No further beats are driven and no response is awaited.
- Pixel handshake: a pixel is pushed when pixel_valid & pixel_ready.
  - pixel_ready = (state != IDLE) & !fifo_full.
  - Simultaneous push and pop leaves the count unchanged.
  - Pixels are never dropped.
- Counters:
  - r: row inside the block, 0..BLOCK_SIZE-1.
  - bx: block column, 0..frame_width/BLOCK_SIZE-1.
  - by: block row, 0..frame_height/BLOCK_SIZE-1.
  - Advance after each write_done: r first, then bx, then by.
- Address: write_addr = base + ((by*BLOCK_SIZE + r)*frame_width + bx*BLOCK_SIZE)*4.
  - Computed in 32-bit unsigned arithmetic, truncated to ADDR_WIDTH.
  - Registered, stable from the start_write cycle until write_done.
- write_len = BLOCK_SIZE-1 in every burst.
- FSM:
  - IDLE: start_of_frame latches dimensions and base, clears counters -> COLLECT.
  - COLLECT: fifo_count >= BLOCK_SIZE -> ISSUE.
  - ISSUE: start_write = 1 for exactly this one cycle -> DATA.
  - DATA: write_data = FIFO head. Each write_beat_ack pops one entry. After BLOCK_SIZE acks -> RESP.
  - RESP: on write_done, advance counters. If this was the last row of the last block -> DONE, else -> COLLECT.
  - DONE: frame_done = 1 for one cycle -> IDLE.
- Latency: if the BLOCK_SIZE-th pixel of a row is handshaken in cycle t while in COLLECT, start_write is high in cycle t+2.
- Edge cases:
  - start_of_frame outside IDLE is ignored.
  - write_beat_ack outside DATA and write_done outside RESP are ignored.
  - write_beat_ack while the FIFO is empty in DATA cannot occur, because DATA is entered only with at least BLOCK_SIZE entries.
- Pixels for the next row may be pushed during DATA and RESP, up to FIFO_DEPTH.
- FIFO pointers wrap modulo FIFO_DEPTH. full = (count == FIFO_DEPTH).

Test Plan:
- 16x16 frame, base_addr_in=0x100, pixels i=0..255 with pixel_data=i, write_beat_ack always 1, write_done 2 cycles after the last beat -> 32 bursts.
  - Burst 0: addr 0x100, data 0..7.
  - Burst 1 (block0, r1): addr 0x140.
  - Burst 8 (block1, r0): addr 0x120.
  - Burst 16 (block2, r0): addr 0x300.
  - Burst 31: addr 0x4E0.
  - write_len=7 in every burst.
  - frame_done pulses exactly once, 1 cycle after the last write_done.
- Hold write_beat_ack=0 while streaming pixels -> pixel_ready drops once 16 pixels are buffered. Release -> all data is written in order with no loss or duplication.
- 8th pixel handshake at cycle t -> start_write high at cycle t+2 for exactly 1 cycle, write_addr valid in the same cycle.
- start_of_frame pulsed mid-frame and pixel_valid asserted in IDLE -> both ignored; pixel_ready=0 in IDLE; counters unchanged.
- Assert rst during DATA after 3 beats -> next cycle all outputs 0, FIFO empty. A new frame then runs correctly from burst 0.
- 8x8 frame -> 8 bursts at base+0x00, base+0x20, ..., base+0xE0; frame_done after the 8th write_done.
